// File: rtl/axis_datapath_scheduler.sv
// Packet-level round-robin scheduler sharing one fixed-latency datapath between
// NUM_SRC AXI-Stream sources; results are tagged in order with the owning source ID.
module axis_datapath_scheduler #(
  parameter int NUM_SRC      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int MAX_INFLIGHT = 4,
  parameter int GAP_CYCLES   = 0,
  localparam int ID_W        = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]            s_axis_tvalid,
  input  logic [NUM_SRC-1:0]            s_axis_tlast,
  output logic [NUM_SRC-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]         dp_tdata,
  output logic                          dp_tvalid,
  output logic                          dp_tlast,
  input  logic [DATA_WIDTH-1:0]         dp_res_tdata,
  input  logic                          dp_res_tvalid,
  input  logic                          dp_res_tlast,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  output logic [ID_W-1:0]               m_axis_tdest,
  output logic                          busy,
  output logic                          err_unexpected
);

  localparam int PW = $clog2(MAX_INFLIGHT);
  localparam logic [7:0] GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  // state | meaning
  // IDLE  | waiting for a valid source and a free ID FIFO slot
  // XFER  | forwarding the granted source's packet to dp_*
  // GAP   | forced idle between packets, gap_cnt counts down to 0
  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, GAP = 2'd2} state_t;

  state_t                state_q, state_d;
  logic [ID_W-1:0]       grant_q, grant_d;
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [7:0]            gap_cnt_q, gap_cnt_d;
  logic [ID_W-1:0]       pick_id, next_ptr;
  logic [ID_W:0]         rr_sum;
  logic                  pick_found;
  logic                  beat, beat_last, push, pop;

  logic [ID_W-1:0]       fifo_q [MAX_INFLIGHT];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [PW:0]           count_q;
  logic                  fifo_full, fifo_empty;

  logic [DATA_WIDTH-1:0] src_data [NUM_SRC];
  logic [DATA_WIDTH-1:0] dp_tdata_q, m_tdata_q;
  logic                  dp_tvalid_q, dp_tlast_q, m_tvalid_q, m_tlast_q, err_q;
  logic [ID_W-1:0]       m_tdest_q;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign src_data[i] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign fifo_full  = (count_q == (PW+1)'(MAX_INFLIGHT));
  assign fifo_empty = (count_q == '0);
  assign beat       = (state_q == XFER) && s_axis_tvalid[grant_q];
  assign beat_last  = beat && s_axis_tlast[grant_q];
  assign next_ptr   = (grant_q == ID_W'(NUM_SRC - 1)) ? '0 : grant_q + 1'b1;
  assign pop        = dp_res_tvalid && dp_res_tlast && !fifo_empty;

  // First valid source at or after rr_ptr, wrapping modulo NUM_SRC
  always_comb begin
    rr_sum     = '0;
    pick_found = 1'b0;
    pick_id    = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      rr_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (rr_sum >= (ID_W+1)'(NUM_SRC)) rr_sum = rr_sum - (ID_W+1)'(NUM_SRC);
      if (!pick_found && s_axis_tvalid[rr_sum[ID_W-1:0]]) begin
        pick_found = 1'b1;
        pick_id    = rr_sum[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    gap_cnt_d = gap_cnt_q;
    push      = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found && !fifo_full) begin
          grant_d = pick_id;
          push    = 1'b1;
          state_d = XFER;
        end
      end
      XFER: begin
        if (beat_last) begin
          rr_ptr_d = next_ptr;
          if (GAP_CYCLES > 0) begin
            state_d   = GAP;
            gap_cnt_d = GAP_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == 8'd0) state_d = IDLE;
        else gap_cnt_d = gap_cnt_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_axis_tready = '0;
    if (state_q == XFER) s_axis_tready[grant_q] = 1'b1;
    busy = (state_q != IDLE) || !fifo_empty;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_tdata_q  <= '0;
      dp_tvalid_q <= 1'b0;
      dp_tlast_q  <= 1'b0;
    end else begin
      dp_tvalid_q <= beat;
      dp_tlast_q  <= beat_last;
      if (beat) dp_tdata_q <= src_data[grant_q];
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= pick_id;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Results with no outstanding packet are still forwarded, tagged as source 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      m_tdest_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      m_tdata_q  <= dp_res_tdata;
      m_tvalid_q <= dp_res_tvalid;
      m_tlast_q  <= dp_res_tlast;
      m_tdest_q  <= fifo_empty ? '0 : fifo_q[rd_ptr_q];
      err_q      <= err_q | (dp_res_tvalid && dp_res_tlast && fifo_empty);
    end
  end

  assign dp_tdata       = dp_tdata_q;
  assign dp_tvalid      = dp_tvalid_q;
  assign dp_tlast       = dp_tlast_q;
  assign m_axis_tdata   = m_tdata_q;
  assign m_axis_tvalid  = m_tvalid_q;
  assign m_axis_tlast   = m_tlast_q;
  assign m_axis_tdest   = m_tdest_q;
  assign err_unexpected = err_q;

endmodule

// File: tb/tb_axis_datapath_scheduler.sv
// Bench for axis_datapath_scheduler: a GAP_CYCLES=0 and a GAP_CYCLES=3 instance,
// a delay-line loopback as the datapath, and an in-order result scoreboard.
module tb_axis_datapath_scheduler;
  localparam int NS = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NS*DW-1:0] s_tdata;
  logic [NS-1:0]    s_tvalid, s_tlast;
  logic [NS-1:0]    rdy0, rdy1;
  logic [DW-1:0]    dpd0, dpd1, md0, md1, res_d, inj_d;
  logic             dpv0, dpv1, dpl0, dpl1, mv0, mv1, ml0, ml1;
  logic [1:0]       mt0, mt1;
  logic             busy0, busy1, err0, err1;
  logic             res_v, res_l, inj_v, inj_l;
  logic             sel, inj_en, mon_en;
  logic [5:0]       lat_idx;

  logic [DW-1:0] dly_d [64];
  logic          dly_v [64];
  logic          dly_l [64];

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] t;
    logic       l;
  } res_t;
  res_t sb[$];

  typedef struct {
    logic [3:0] mask;
    logic [1:0] exp_g;
  } vec_t;
  vec_t vt [12];

  int n_cmp = 0;
  int n_fail = 0;
  int res_cnt = 0;

  axis_datapath_scheduler #(.NUM_SRC(NS), .DATA_WIDTH(DW), .MAX_INFLIGHT(4), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast), .s_axis_tready(rdy0), .dp_tdata(dpd0), .dp_tvalid(dpv0),
    .dp_tlast(dpl0), .dp_res_tdata(res_d), .dp_res_tvalid(res_v), .dp_res_tlast(res_l),
    .m_axis_tdata(md0), .m_axis_tvalid(mv0), .m_axis_tlast(ml0), .m_axis_tdest(mt0),
    .busy(busy0), .err_unexpected(err0));

  axis_datapath_scheduler #(.NUM_SRC(NS), .DATA_WIDTH(DW), .MAX_INFLIGHT(4), .GAP_CYCLES(3)) dut1 (
    .clk(clk), .rst(rst), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast), .s_axis_tready(rdy1), .dp_tdata(dpd1), .dp_tvalid(dpv1),
    .dp_tlast(dpl1), .dp_res_tdata(res_d), .dp_res_tvalid(res_v), .dp_res_tlast(res_l),
    .m_axis_tdata(md1), .m_axis_tvalid(mv1), .m_axis_tlast(ml1), .m_axis_tdest(mt1),
    .busy(busy1), .err_unexpected(err1));

  // Fixed-latency datapath model fed by the selected instance
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) begin
        dly_d[i] <= '0;
        dly_v[i] <= 1'b0;
        dly_l[i] <= 1'b0;
      end
    end else begin
      dly_d[0] <= sel ? dpd1 : dpd0;
      dly_v[0] <= sel ? dpv1 : dpv0;
      dly_l[0] <= sel ? dpl1 : dpl0;
      for (int i = 1; i < 64; i++) begin
        dly_d[i] <= dly_d[i-1];
        dly_v[i] <= dly_v[i-1];
        dly_l[i] <= dly_l[i-1];
      end
    end
  end

  assign res_d = inj_en ? inj_d : dly_d[lat_idx];
  assign res_v = inj_en ? inj_v : dly_v[lat_idx];
  assign res_l = inj_en ? inj_l : dly_l[lat_idx];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && (sel ? mv1 : mv0)) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_extra: got result %0h expected none", sel ? md1 : md0);
      end else begin
        res_t e;
        e = sb.pop_front();
        chk("m_tdata", sel ? md1 : md0, e.d);
        chk("m_tdest", sel ? mt1 : mt0, e.t);
        chk("m_tlast", sel ? ml1 : ml0, e.l);
      end
      if (sel ? ml1 : ml0) res_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    inj_en   = 1'b0;
    sb.delete();
    res_cnt  = 0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) step();
    chk("drain_left", sb.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] ord5 [5];
    logic [1:0] g;
    int grants, c4;
    bit found;

    vt[0]  = '{4'b0001, 2'd0};  vt[1]  = '{4'b0001, 2'd0};
    vt[2]  = '{4'b1111, 2'd1};  vt[3]  = '{4'b1001, 2'd3};
    vt[4]  = '{4'b1010, 2'd1};  vt[5]  = '{4'b0011, 2'd0};
    vt[6]  = '{4'b1100, 2'd2};  vt[7]  = '{4'b0111, 2'd0};
    vt[8]  = '{4'b1111, 2'd1};  vt[9]  = '{4'b0100, 2'd2};
    vt[10] = '{4'b1111, 2'd3};  vt[11] = '{4'b1111, 2'd0};
    ord5 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    sel = 1'b0; mon_en = 1'b1; inj_d = '0; inj_v = 1'b0; inj_l = 1'b0;
    lat_idx = 6'd1;
    do_reset();

    chk("rst_tready", rdy0, 0);
    chk("rst_dp_tvalid", dpv0, 0);
    chk("rst_dp_tdata", dpd0, 0);
    chk("rst_m_tvalid", mv0, 0);
    chk("rst_m_tdest", mt0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_err", err0, 0);
    chk("rst_busy_gap", busy1, 0);

    // 1-beat packets, back to back; latency 2 lines results up with later grants
    for (int k = 0; k < 12; k++) begin
      s_tvalid = vt[k].mask;
      s_tlast  = 4'hF;
      s_tdata  = {8'(48 + k), 8'(32 + k), 8'(16 + k), 8'(k)};
      step();
      chk("rr_tready", rdy0, 4'b0001 << vt[k].exp_g);
      step();
      chk("rr_dp_tvalid", dpv0, 1);
      chk("rr_dp_tdata", dpd0, {2'b00, vt[k].exp_g, 4'(k)});
      chk("rr_dp_tlast", dpl0, 1);
      chk("rr_tready_off", rdy0, 0);
      sb.push_back({2'b00, vt[k].exp_g, 4'(k), vt[k].exp_g, 1'b1});
      s_tvalid = '0;
    end
    wait_drain(50);
    chk("rr_busy_end", busy0, 0);
    chk("rr_err_end", err0, 0);

    // Single 3-beat packet from src0
    do_reset();
    lat_idx = 6'd9;
    s_tvalid = 4'b0001; s_tlast = '0; s_tdata = {24'h0, 8'hA1};
    step();
    chk("t1_tready", rdy0, 4'b0001);
    chk("t1_dp_idle", dpv0, 0);
    step();
    chk("t1_dpA_v", dpv0, 1); chk("t1_dpA_d", dpd0, 8'hA1); chk("t1_dpA_l", dpl0, 0);
    sb.push_back({8'hA1, 2'd0, 1'b0});
    s_tdata = {24'h0, 8'hB2};
    step();
    chk("t1_dpB_d", dpd0, 8'hB2); chk("t1_dpB_l", dpl0, 0);
    sb.push_back({8'hB2, 2'd0, 1'b0});
    s_tdata = {24'h0, 8'hC3}; s_tlast = 4'b0001;
    step();
    chk("t1_dpC_d", dpd0, 8'hC3); chk("t1_dpC_l", dpl0, 1); chk("t1_tready_off", rdy0, 0);
    sb.push_back({8'hC3, 2'd0, 1'b1});
    s_tvalid = '0;
    step();
    chk("t1_dp_after_v", dpv0, 0); chk("t1_dp_after_l", dpl0, 0); chk("t1_dp_hold", dpd0, 8'hC3);
    wait_drain(40);

    // All sources valid, 2-beat packets
    do_reset();
    s_tvalid = 4'hF; s_tlast = '0;
    s_tdata  = {8'h31, 8'h21, 8'h11, 8'h01};
    for (int p = 0; p < 5; p++) begin
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
        step();
        if (rdy0 != '0) found = 1'b1;
      end
      g = ord5[p];
      chk("t2_grant", rdy0, 4'b0001 << g);
      step();
      chk("t2_beat1", dpd0, {2'b00, g, 4'h1});
      s_tlast = 4'b0001 << g;
      s_tdata = {8'h32, 8'h22, 8'h12, 8'h02};
      step();
      chk("t2_beat2", dpd0, {2'b00, g, 4'h2});
      chk("t2_beat2_l", dpl0, 1);
      sb.push_back({2'b00, g, 4'h1, g, 1'b0});
      sb.push_back({2'b00, g, 4'h2, g, 1'b1});
      s_tlast = '0;
      s_tdata = {8'h31, 8'h21, 8'h11, 8'h01};
    end
    s_tvalid = '0;
    wait_drain(60);

    // Long datapath: fifth grant waits for the first result
    do_reset();
    lat_idx = 6'd39;
    s_tvalid = 4'b0010; s_tlast = 4'b0010; s_tdata = {16'h0, 8'h5C, 8'h0};
    grants = 0; c4 = 0;
    for (int c = 0; c < 300 && grants < 12; c++) begin
      step();
      if (rdy0 != '0) begin
        grants++;
        chk("t3_tready", rdy0, 4'b0010);
        sb.push_back({8'h5C, 2'd1, 1'b1});
        if (grants == 4) c4 = c;
        if (grants == 5) begin
          chk("t3_res_before_5th", res_cnt, 1);
          chk("t3_withheld", 32'((c - c4) > 30), 1);
        end
      end
    end
    chk("t3_grants", grants, 12);
    step();
    s_tvalid = '0;
    wait_drain(200);
    chk("t3_busy_end", busy0, 0);
    chk("t3_err_end", err0, 0);

    // Gap instance: exact gap length and mid-packet tvalid holes
    sel = 1'b1;
    do_reset();
    lat_idx = 6'd3;
    s_tvalid = 4'b0001; s_tlast = 4'b0001; s_tdata = {24'h0, 8'h77};
    step();
    chk("t4_grant0", rdy1, 4'b0001);
    step();
    chk("t4_dp_v", dpv1, 1); chk("t4_dp_l", dpl1, 1); chk("t4_gap_tready", rdy1, 0);
    sb.push_back({8'h77, 2'd0, 1'b1});
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_gap_rdy", rdy1, 0);
      chk("t4_gap_dpv", dpv1, 0);
    end
    step();
    chk("t4_regrant", rdy1, 4'b0001);
    s_tlast = '0; s_tvalid = 4'b0011; s_tdata = {16'h0, 8'h91, 8'h81};
    step();
    chk("t4_b1_v", dpv1, 1); chk("t4_b1_d", dpd1, 8'h81); chk("t4_b1_l", dpl1, 0);
    s_tvalid = 4'b0010;
    step();
    chk("t4_hole_v", dpv1, 0); chk("t4_hole_l", dpl1, 0);
    chk("t4_hole_d", dpd1, 8'h81); chk("t4_hole_rdy", rdy1, 4'b0001);
    s_tvalid = 4'b0011; s_tlast = 4'b0001; s_tdata = {16'h0, 8'h91, 8'h82};
    step();
    chk("t4_b2_d", dpd1, 8'h82); chk("t4_b2_l", dpl1, 1); chk("t4_b2_rdy", rdy1, 0);
    sb.push_back({8'h81, 2'd0, 1'b0});
    sb.push_back({8'h82, 2'd0, 1'b1});
    s_tvalid = 4'b0010; s_tlast = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_gap2_rdy", rdy1, 0);
    end
    step();
    chk("t4_grant1", rdy1, 4'b0010);
    step();
    chk("t4_src1_d", dpd1, 8'h91); chk("t4_src1_l", dpl1, 1);
    sb.push_back({8'h91, 2'd1, 1'b1});
    s_tvalid = '0;
    wait_drain(40);
    sel = 1'b0;

    // Result with nothing outstanding
    do_reset();
    mon_en = 1'b0;
    inj_en = 1'b1; inj_v = 1'b1; inj_l = 1'b1; inj_d = 8'h5A;
    step();
    chk("t5_m_v", mv0, 1); chk("t5_m_d", md0, 8'h5A); chk("t5_m_dest", mt0, 0);
    chk("t5_m_l", ml0, 1); chk("t5_err", err0, 1);
    inj_v = 1'b0; inj_l = 1'b0;
    step();
    step();
    chk("t5_err_sticky", err0, 1); chk("t5_m_v_off", mv0, 0); chk("t5_busy", busy0, 0);
    inj_en = 1'b0;

    // Reset in the middle of a packet
    do_reset();
    lat_idx = 6'd9;
    s_tvalid = 4'b0010; s_tlast = '0; s_tdata = {16'h0, 8'h44, 8'h0};
    step();
    chk("t6_grant1", rdy0, 4'b0010);
    step();
    chk("t6_dp_v", dpv0, 1); chk("t6_busy", busy0, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_rdy", rdy0, 0); chk("t6_rst_dpv", dpv0, 0); chk("t6_rst_busy", busy0, 0);
    s_tvalid = 4'hF; s_tlast = 4'hF; s_tdata = {8'h33, 8'h22, 8'h11, 8'h00};
    step();
    step();
    rst = 1'b0;
    step();
    chk("t6_after_rst_grant", rdy0, 4'b0001);
    step();
    s_tvalid = '0;
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
